// File: rtl/altusoc_uart_pkg.sv
// rtl/altusoc_uart_pkg.sv - shared constants and state encodings for the WB UART
package altusoc_uart_pkg;

  localparam logic [3:0] REG_DATA = 4'h0;
  localparam logic [3:0] REG_STAT = 4'h4;
  localparam logic [3:0] REG_DIV  = 4'h8;
  localparam logic [3:0] REG_IE   = 4'hC;

  localparam int STAT_TX_FULL    = 0;
  localparam int STAT_TX_EMPTY   = 1;
  localparam int STAT_RX_VALID   = 2;
  localparam int STAT_RX_FULL    = 3;
  localparam int STAT_RX_OVERRUN = 4;
  localparam int STAT_FRAME_ERR  = 5;
  localparam int STAT_TX_BUSY    = 6;

  localparam int IE_RX = 0;
  localparam int IE_TX = 1;

  localparam int OVS  = 16;
  localparam int BITS = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/altusoc_wb_uart_if.sv
// rtl/altusoc_wb_uart_if.sv - Wishbone slave bundle between interconnect and UART
interface altusoc_wb_uart_if;
  logic [3:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/altusoc_sync_fifo.sv
// rtl/altusoc_sync_fifo.sv - single-clock FIFO with push/pop passthrough when full or empty
module altusoc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             bypass;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // An empty FIFO hands a same-cycle push straight to the popper without storing it.
  assign bypass = empty & push & pop;
  assign wr_en  = push & (~full | pop) & ~bypass;
  assign rd_en  = pop & ~empty;
  assign dout   = empty ? din : mem[rd_ptr];

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/altusoc_wb_uart.sv
// rtl/altusoc_wb_uart.sv - Wishbone UART, 8N1, 16x oversampling, TX/RX FIFOs and level irq
module altusoc_wb_uart
  import altusoc_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd26
) (
  input  logic             clk,
  input  logic             rst_n,
  altusoc_wb_uart_if.slave wb,
  input  logic             i_rx,
  output logic             o_tx,
  output logic             o_irq
);
  logic [3:0]  reg_off;
  logic        req, wr, rd;
  logic        data_wr, data_rd, stat_wr, div_wr, ie_wr;
  logic [31:0] rd_val;
  logic [6:0]  stat;
  logic        unused_bits;

  logic [15:0] div, tick_cnt;
  logic        tick;
  logic [1:0]  ie;
  logic        rx_overrun, frame_err;

  logic        tx_full, tx_empty, tx_pop, tx_busy;
  logic [7:0]  tx_dout;
  tx_state_t   tx_state, tx_state_n;
  logic [3:0]  tx_ovs, tx_ovs_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_line_n;

  logic        rx_meta, rx_sync, rx_prev;
  logic        rx_full, rx_empty, rx_avail;
  logic        rx_push, rx_ovr_set, rx_ferr_set;
  logic [7:0]  rx_dout;
  rx_state_t   rx_state, rx_state_n;
  logic [3:0]  rx_ovs, rx_ovs_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;

  assign unused_bits = ^{wb.i_wb_adr[1:0], wb.i_wb_dat[31:16], wb.i_wb_sel[3:2]};

  assign reg_off = {wb.i_wb_adr[3:2], 2'b00};
  // Side effects fire only on the request cycle that raises ack.
  assign req     = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_ack;
  assign wr      = req & wb.i_wb_we;
  assign rd      = req & ~wb.i_wb_we;
  assign data_wr = wr & (reg_off == REG_DATA) & wb.i_wb_sel[0];
  assign data_rd = rd & (reg_off == REG_DATA);
  assign stat_wr = wr & (reg_off == REG_STAT) & wb.i_wb_sel[0];
  assign div_wr  = wr & (reg_off == REG_DIV);
  assign ie_wr   = wr & (reg_off == REG_IE) & wb.i_wb_sel[0];

  assign tx_busy  = (tx_state != TX_IDLE);
  assign rx_avail = ~rx_empty | rx_push;
  assign tick     = (tick_cnt >= div);

  altusoc_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(data_wr), .pop(tx_pop),
    .din(wb.i_wb_dat[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  altusoc_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(data_rd),
    .din(rx_shift), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  // Status word and read-data mux.
  always_comb begin
    stat                  = '0;
    stat[STAT_TX_FULL]    = tx_full;
    stat[STAT_TX_EMPTY]   = tx_empty;
    stat[STAT_RX_VALID]   = ~rx_empty;
    stat[STAT_RX_FULL]    = rx_full;
    stat[STAT_RX_OVERRUN] = rx_overrun;
    stat[STAT_FRAME_ERR]  = frame_err;
    stat[STAT_TX_BUSY]    = tx_busy;
    rd_val = '0;
    case (reg_off)
      REG_DATA: rd_val[7:0]  = rx_avail ? rx_dout : 8'h00;
      REG_STAT: rd_val[6:0]  = stat;
      REG_DIV:  rd_val[15:0] = div;
      REG_IE:   rd_val[1:0]  = ie;
      default:  rd_val = '0;
    endcase
  end

  // Single-cycle ack with registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.o_wb_ack <= 1'b0;
      wb.o_wb_rdt <= '0;
    end else begin
      wb.o_wb_ack <= req;
      wb.o_wb_rdt <= rd ? rd_val : 32'h0;
    end
  end

  // Control registers and sticky error bits; a set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= DEFAULT_DIV;
      ie         <= '0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (div_wr && wb.i_wb_sel[0]) div[7:0]  <= wb.i_wb_dat[7:0];
      if (div_wr && wb.i_wb_sel[1]) div[15:8] <= wb.i_wb_dat[15:8];
      if (ie_wr) ie <= wb.i_wb_dat[1:0];
      if (rx_ovr_set) rx_overrun <= 1'b1;
      else if (stat_wr && wb.i_wb_dat[STAT_RX_OVERRUN]) rx_overrun <= 1'b0;
      if (rx_ferr_set) frame_err <= 1'b1;
      else if (stat_wr && wb.i_wb_dat[STAT_FRAME_ERR]) frame_err <= 1'b0;
    end
  end

  // 16x tick generator; >= keeps it safe when DIV shrinks below the running count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else if (div_wr || tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 16'd1;
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_irq <= 1'b0;
    else o_irq <= (ie[IE_RX] & ~rx_empty) | (ie[IE_TX] & tx_empty & ~tx_busy);
  end

  // TX state register; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_ovs   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      o_tx     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_ovs   <= tx_ovs_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      o_tx     <= tx_line_n;
    end
  end

  // TX next state: every line change happens on a tick so bit edges stay tick-aligned.
  always_comb begin
    tx_state_n = tx_state;
    tx_ovs_n   = tx_ovs;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = o_tx;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: if (tick && !tx_empty) begin
        tx_pop     = 1'b1;
        tx_shift_n = tx_dout;
        tx_ovs_n   = '0;
        tx_line_n  = 1'b0;
        tx_state_n = TX_START;
      end
      TX_START: if (tick) begin
        if (tx_ovs == 4'(OVS-1)) begin
          tx_ovs_n   = '0;
          tx_bit_n   = '0;
          tx_line_n  = tx_shift[0];
          tx_state_n = TX_DATA;
        end else tx_ovs_n = tx_ovs + 4'd1;
      end
      TX_DATA: if (tick) begin
        if (tx_ovs == 4'(OVS-1)) begin
          tx_ovs_n = '0;
          if (tx_bit == 3'(BITS-1)) begin
            tx_line_n  = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_line_n  = tx_shift[1];
          end
        end else tx_ovs_n = tx_ovs + 4'd1;
      end
      TX_STOP: if (tick) begin
        if (tx_ovs == 4'(OVS-1)) tx_state_n = TX_IDLE;
        else tx_ovs_n = tx_ovs + 4'd1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Two-flop synchroniser plus delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_ovs   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_ovs   <= rx_ovs_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX next state: half-bit wait to centre on the start bit, then full-bit spacing.
  always_comb begin
    rx_state_n  = rx_state;
    rx_ovs_n    = rx_ovs;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_push     = 1'b0;
    rx_ovr_set  = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_sync) begin
        rx_ovs_n   = '0;
        rx_state_n = RX_START;
      end
      RX_START: if (tick) begin
        if (rx_ovs == 4'(OVS/2-1)) begin
          rx_ovs_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else rx_ovs_n = rx_ovs + 4'd1;
      end
      RX_DATA: if (tick) begin
        if (rx_ovs == 4'(OVS-1)) begin
          rx_ovs_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          if (rx_bit == 3'(BITS-1)) rx_state_n = RX_STOP;
          else rx_bit_n = rx_bit + 3'd1;
        end else rx_ovs_n = rx_ovs + 4'd1;
      end
      RX_STOP: if (tick) begin
        if (rx_ovs == 4'(OVS-1)) begin
          rx_ovs_n   = '0;
          rx_state_n = RX_IDLE;
          if (!rx_sync) rx_ferr_set = 1'b1;
          else if (rx_full) rx_ovr_set = 1'b1;
          else rx_push = 1'b1;
        end else rx_ovs_n = rx_ovs + 4'd1;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_altusoc_wb_uart.sv
// tb/tb_altusoc_wb_uart.sv - self-checking bench for the WB UART
module tb_altusoc_wb_uart;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_drv = 1'b1;
  logic loopback = 1'b0;
  logic mon_en = 1'b0;
  logic o_tx, o_irq;
  logic rx_line;
  logic [31:0] d;
  logic [2:0] ack_pat;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] rx_q[$];
  logic ovr_m = 1'b0;
  logic ferr_m = 1'b0;

  always #5 clk = ~clk;
  assign rx_line = loopback ? o_tx : rx_drv;

  altusoc_wb_uart_if bus();

  altusoc_wb_uart #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd26)) dut (
    .clk(clk), .rst_n(rst_n), .wb(bus), .i_rx(rx_line), .o_tx(o_tx), .o_irq(o_irq)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [3:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    int n;
    @(posedge clk); #1;
    bus.i_wb_adr = adr; bus.i_wb_we = we; bus.i_wb_dat = dat; bus.i_wb_sel = sel;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.o_wb_ack && n < 10);
    if (!bus.o_wb_ack) check("wb_ack_timeout", {31'b0, bus.o_wb_ack}, 32'h1);
    rdat = bus.o_wb_rdt;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_xfer(adr, 1'b1, dat, sel, dummy);
  endtask

  task automatic rd(input logic [3:0] adr, output logic [31:0] rdat);
    wb_xfer(adr, 1'b0, 32'h0, 4'hF, rdat);
  endtask

  task automatic send(input logic [7:0] b);
    exp_tx_q.push_back(b);
    wr(4'h0, {24'h0, b}, 4'h1);
  endtask

  // Model: the receiver keeps up to 8 bytes; a further good frame only flags overrun.
  function automatic void rx_model_push(input logic [7:0] b);
    if (rx_q.size() < 8) rx_q.push_back(b);
    else ovr_m = 1'b1;
  endfunction

  function automatic logic [31:0] rx_model_read();
    if (rx_q.size() == 0) return 32'h0;
    return {24'h0, rx_q.pop_front()};
  endfunction

  // Expected STAT for an idle transmitter with an empty TX FIFO.
  function automatic logic [31:0] model_stat_idle();
    logic [31:0] s;
    s = 32'h0;
    s[1] = 1'b1;
    s[2] = (rx_q.size() != 0);
    s[3] = (rx_q.size() == 8);
    s[4] = ovr_m;
    s[5] = ferr_m;
    return s;
  endfunction

  // Line level i clocks after the start bit begins, at one clock per tick.
  function automatic logic wave_exp(input logic [7:0] b, input int i);
    int seg;
    seg = i / 16;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return b[seg-1];
    return 1'b1;
  endfunction

  task automatic wait_tx_drain(input int budget);
    int n;
    n = 0;
    while (exp_tx_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    check("tx_drain_remaining", exp_tx_q.size(), 0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
  endtask

  // Compare process: decodes every transmitted frame mid-bit (DIV=0 timing) against the queue.
  always begin : tx_mon
    logic [7:0] b;
    logic sb, pb;
    @(posedge clk); #2;
    if (mon_en && rst_n && o_tx === 1'b0) begin
      repeat (8) @(posedge clk);
      #2 sb = o_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(posedge clk);
        #2 b[i] = o_tx;
      end
      repeat (16) @(posedge clk);
      #2 pb = o_tx;
      check("tx_start_bit", {31'b0, sb}, 32'h0);
      check("tx_stop_bit", {31'b0, pb}, 32'h1);
      if (exp_tx_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL tx_unexpected_frame: got 0x%0h, expected no frame", b);
      end else begin
        check("tx_byte", {24'h0, b}, {24'h0, exp_tx_q.pop_front()});
        if (loopback) rx_model_push(b);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_wb_adr = '0; bus.i_wb_dat = '0; bus.i_wb_sel = '0;
    bus.i_wb_we = 1'b0; bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;

    // 1: reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'b0, bus.o_wb_ack}, 32'h0);
    check("reset_rdt", bus.o_wb_rdt, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx", {31'b0, o_tx}, 32'h1);
    check("reset_irq", {31'b0, o_irq}, 32'h0);
    rd(4'h4, d); check("reset_stat", d, 32'h02);
    rd(4'h8, d); check("reset_div", d, 32'h1A);
    rd(4'hC, d); check("reset_ie", d, 32'h0);

    // ack never held for two cycles even with a held strobe
    @(posedge clk); #1;
    bus.i_wb_adr = 4'hC; bus.i_wb_we = 1'b0; bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; ack_pat[i] = bus.o_wb_ack; end
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    check("ack_pattern", {29'b0, ack_pat}, 32'h5);

    // DIV byte lanes
    wr(4'h8, 32'hFFFF_1234, 4'b0001); rd(4'h8, d); check("div_lane0", d, 32'h34);
    wr(4'h8, 32'h0000_AB00, 4'b0010); rd(4'h8, d); check("div_lane1", d, 32'hAB34);
    wr(4'h8, 32'h0, 4'b0011); rd(4'h8, d); check("div_zero", d, 32'h0);

    // tx-idle interrupt
    wr(4'hC, 32'h2, 4'h1); repeat (2) @(posedge clk); #1;
    check("irq_tx_idle", {31'b0, o_irq}, 32'h1);
    wr(4'hC, 32'h0, 4'h1); repeat (2) @(posedge clk); #1;
    check("irq_off", {31'b0, o_irq}, 32'h0);

    // 2: single byte 0x55, exact waveform
    mon_en = 1'b1;
    send(8'h55);
    fork
      begin : wave
        int k, bad;
        k = 0; bad = 0;
        do begin @(posedge clk); #2; k++; end while (o_tx !== 1'b0 && k < 20);
        for (int i = 0; i < 160; i++) begin
          if (o_tx !== wave_exp(8'h55, i)) bad++;
          @(posedge clk); #2;
        end
        check("tx_wave_bad_cycles", bad, 0);
      end
      begin
        repeat (80) @(posedge clk);
        rd(4'h4, d); check("stat_busy_mid", d, 32'h42);
      end
    join
    repeat (10) @(posedge clk);
    rd(4'h4, d); check("stat_after_tx", d, 32'h02);

    // 3: loopback 0xA3 with rx interrupt
    loopback = 1'b1;
    wr(4'hC, 32'h1, 4'h1);
    send(8'hA3);
    begin
      int n;
      n = 0;
      while (!o_irq && n < 400) begin @(posedge clk); #1; n++; end
    end
    check("irq_rx", {31'b0, o_irq}, 32'h1);
    rd(4'h0, d);
    check("rx_loop_model", d, rx_model_read());
    check("rx_loop_a3", d, 32'hA3);
    rd(4'h4, d); check("rx_valid_cleared", {31'b0, d[2]}, 32'h0);
    repeat (2) @(posedge clk); #1;
    check("irq_cleared", {31'b0, o_irq}, 32'h0);
    wr(4'hC, 32'h0, 4'h1);

    // 4: nine bytes into an 8-deep receiver
    for (int i = 1; i <= 9; i++) send(8'(i));
    rd(4'h4, d); check("stat_tx_full", d, 32'h41);
    wait_tx_drain(3000);
    repeat (60) @(posedge clk);
    rd(4'h4, d);
    check("stat_rx_overrun_model", d, model_stat_idle());
    check("stat_rx_overrun_lit", d, 32'h1E);
    rd(4'h0, d); check("rx_first_lit", d, 32'h01);
    void'(rx_model_read());
    for (int i = 0; i < 8; i++) begin
      rd(4'h0, d); check("rx_read_seq", d, rx_model_read());
    end
    wr(4'h4, 32'h10, 4'h1); ovr_m = 1'b0;
    rd(4'h4, d); check("stat_w1c_overrun", d, model_stat_idle());

    // 5: false start and framing error from a directly driven line
    loopback = 1'b0;
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    rd(4'h4, d); check("false_start", d, 32'h02);
    rx_frame(8'h5A, 1'b0);
    repeat (40) @(posedge clk);
    rd(4'h4, d); check("frame_err", d, 32'h22);
    rx_frame(8'hC3, 1'b1);
    repeat (20) @(posedge clk);
    rd(4'h0, d); check("rx_driven_c3", d, 32'hC3);
    wr(4'h4, 32'h20, 4'h1);
    rd(4'h4, d); check("stat_w1c_frame", d, 32'h02);

    // 6: nine back-to-back writes, then reset mid-frame
    for (int i = 0; i < 9; i++) send(8'(8'h10 + i));
    rd(4'h4, d); check("stat_tx_full_6", d, 32'h41);
    wait_tx_drain(3000);
    repeat (20) @(posedge clk);
    mon_en = 1'b0;
    wr(4'h0, 32'h00, 4'h1);
    wr(4'h0, 32'h11, 4'h1);
    repeat (40) @(posedge clk);
    #1 check("tx_low_midframe", {31'b0, o_tx}, 32'h0);
    #2 rst_n = 1'b0;
    #1 check("tx_reset_async", {31'b0, o_tx}, 32'h1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(4'h4, d); check("stat_after_reset", d, 32'h02);
    rd(4'h8, d); check("div_after_reset", d, 32'h1A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
